// File: rtl/uart_hex_reporter.sv
// Report sequencer: turns a measurement word into ASCII hex (MS nibble first, optional CR/LF)
// and feeds the characters one at a time through the UART transmitter's byte handshake.
module uart_hex_reporter #(
  parameter int DATA_WIDTH = 32,
  parameter bit SEND_CRLF  = 1'b1,
  parameter bit UPPERCASE  = 1'b1
) (
  input  logic                  i_Clock,
  input  logic                  i_Rst_L,
  input  logic                  i_Data_DV,
  input  logic [DATA_WIDTH-1:0] i_Data,
  output logic                  o_Busy,
  output logic                  o_Report_Done,
  output logic                  o_Dropped,
  output logic                  o_TX_DV,
  output logic [7:0]            o_TX_Byte,
  input  logic                  i_TX_Done
);

  localparam int DIGITS = DATA_WIDTH / 4;
  localparam int NBYTES = DIGITS + (SEND_CRLF ? 2 : 0);
  localparam int IDX_W  = $clog2(DIGITS + 2) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  // Transmitter handshake: o_TX_DV is a one-cycle strobe that hands o_TX_Byte over; the next
  // byte is only issued after i_TX_Done, which is honoured solely while waiting on a byte.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t state, next_state;

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [IDX_W-1:0]      idx_q, idx_d, idx_inc;
  logic                  busy_d, tx_dv_d, report_done_d, dropped_d;
  logic [7:0]            tx_byte_d;

  assign idx_inc = idx_q + IDX_W'(1);

  function automatic logic [7:0] char_of(input logic [DATA_WIDTH-1:0] d,
                                         input logic [IDX_W-1:0] i);
    logic [7:0] c;
    logic [3:0] nib;
    c   = 8'h0A;
    nib = 4'h0;
    if (int'(i) < DIGITS) begin
      nib = 4'(d >> (4 * (DIGITS - 1 - int'(i))));
      if (nib < 4'd10) c = 8'h30 + {4'h0, nib};
      else             c = (UPPERCASE ? 8'h37 : 8'h57) + {4'h0, nib};
    end else if (int'(i) == DIGITS) begin
      c = 8'h0D;
    end
    return c;
  endfunction

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) state <= S_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (i_Data_DV) next_state = S_SEND;
      S_SEND:  next_state = S_WAIT;
      S_WAIT:  if (i_TX_Done) next_state = (idx_q == LAST_IDX) ? S_IDLE : S_SEND;
      default: next_state = S_IDLE;
    endcase
  end

  // Outputs are computed one cycle ahead so the strobe and byte appear on the entering edge.
  always_comb begin
    data_d        = data_q;
    idx_d         = idx_q;
    busy_d        = o_Busy;
    tx_dv_d       = 1'b0;
    tx_byte_d     = o_TX_Byte;
    report_done_d = 1'b0;
    dropped_d     = i_Data_DV & o_Busy;
    case (state)
      S_IDLE: begin
        if (i_Data_DV) begin
          data_d    = i_Data;
          idx_d     = '0;
          busy_d    = 1'b1;
          tx_dv_d   = 1'b1;
          tx_byte_d = char_of(i_Data, '0);
        end
      end
      S_SEND: begin
      end
      S_WAIT: begin
        if (i_TX_Done) begin
          if (idx_q == LAST_IDX) begin
            report_done_d = 1'b1;
            busy_d        = 1'b0;
          end else begin
            idx_d     = idx_inc;
            tx_dv_d   = 1'b1;
            tx_byte_d = char_of(data_q, idx_inc);
          end
        end
      end
      default: busy_d = 1'b0;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      data_q        <= '0;
      idx_q         <= '0;
      o_Busy        <= 1'b0;
      o_TX_DV       <= 1'b0;
      o_TX_Byte     <= 8'h00;
      o_Report_Done <= 1'b0;
      o_Dropped     <= 1'b0;
    end else begin
      data_q        <= data_d;
      idx_q         <= idx_d;
      o_Busy        <= busy_d;
      o_TX_DV       <= tx_dv_d;
      o_TX_Byte     <= tx_byte_d;
      o_Report_Done <= report_done_d;
      o_Dropped     <= dropped_d;
    end
  end

endmodule
